// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front end for a single-port, byte-lane data memory.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned word/halfword accesses.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic [3:0]        mem_write_n,
  input  logic [2:0]        load,
  input  logic [2:0]        store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              dm_cs,
  output logic [3:0]        dm_web,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_di,
  input  logic [31:0]       dm_do,
  input  logic              dm_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        is_store;
  logic        is_load;
  logic        bad;
  logic [3:0]  st_web;
  logic [31:0] st_di;
  logic [2:0]  load_q;
  logic [1:0]  lsb_q;
  logic        store_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  always_comb begin
    is_store = (mem_write_n == 4'b0000);
    is_load  = mem_read && !is_store;
    st_web   = 4'b0000;
    st_di    = wdata;
    case (store)
      3'd1: begin
        st_web = ~(4'b0001 << addr[1:0]);
        st_di  = {4{wdata[7:0]}};
      end
      3'd2: begin
        st_web = addr[1] ? 4'b0011 : 4'b1100;
        st_di  = {2{wdata[15:0]}};
      end
      default: begin
        st_web = 4'b0000;
        st_di  = wdata;
      end
    endcase
  end

  // Natural alignment fault; bytes can never fault.
  always_comb begin
    bad = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (is_store) begin
      case (store)
        3'd1:    bad = 1'b0;
        3'd2:    bad = addr[0];
        default: bad = |addr[1:0];
      endcase
    end else if (is_load) begin
      case (load)
        3'd1, 3'd4: bad = 1'b0;
        3'd2, 3'd3: bad = addr[0];
        default:    bad = |addr[1:0];
      endcase
    end
`endif
  end

  always_comb begin
    byte_sel = dm_do[{lsb_q, 3'b000} +: 8];
    half_sel = lsb_q[1] ? dm_do[31:16] : dm_do[15:0];
    case (load_q)
      3'd1:    ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    ld_ext = {{16{half_sel[15]}}, half_sel};
      3'd3:    ld_ext = {16'b0, half_sel};
      3'd4:    ld_ext = {24'b0, byte_sel};
      default: ld_ext = dm_do;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      misalign  <= 1'b0;
      dm_cs     <= 1'b0;
      dm_web    <= 4'b1111;
      dm_addr   <= '0;
      dm_di     <= '0;
      load_q    <= '0;
      lsb_q     <= '0;
      store_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            load_q    <= load;
            lsb_q     <= addr[1:0];
            store_q   <= is_store;
            if ((is_store || is_load) && !bad) begin
              state   <= ACCESS;
              dm_cs   <= 1'b1;
              dm_addr <= {addr[ADDR_W-1:2], 2'b00};
              dm_web  <= is_store ? st_web : 4'b1111;
              dm_di   <= is_store ? st_di : 32'h0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rdata     <= '0;
              misalign  <= bad;
            end
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            state     <= RESP;
            dm_cs     <= 1'b0;
            dm_web    <= 4'b1111;
            rsp_valid <= 1'b1;
            rdata     <= store_q ? 32'h0 : ld_ext;
            misalign  <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          dm_cs     <= 1'b0;
          dm_web    <= 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed table, corner sequences and random ops vs model.
// Honours LSU_MISALIGN_CHECK_EN the same way the design does.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic [3:0]  mem_write_n;
  logic [2:0]  load;
  logic [2:0]  store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misalign;
  logic        dm_cs;
  logic [3:0]  dm_web;
  logic [31:0] dm_addr;
  logic [31:0] dm_di;
  logic [31:0] dm_do;
  logic        dm_ack;

  int ntests = 0;
  int nfail  = 0;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write_n(mem_write_n),
    .load(load), .store(store),
    .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .misalign(misalign),
    .dm_cs(dm_cs), .dm_web(dm_web), .dm_addr(dm_addr),
    .dm_di(dm_di), .dm_do(dm_do), .dm_ack(dm_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0h required %0h", n, act, exp);
    end
  endtask

  // Reference: access size, lane start and extension from the ISA rules.
  task automatic model(
    input  logic mr, input logic [3:0] mwn,
    input  logic [2:0] ld, input logic [2:0] st,
    input  logic [31:0] a, input logic [31:0] wd, input logic [31:0] mdo,
    output bit acc, output bit mis,
    output logic [3:0] web, output logic [31:0] di, output logic [31:0] rd);
    int size;
    int start;
    int lsb;
    bit sgn;
    bit st_op;
    bit ld_op;
    longint m;
    longint v;
    st_op = (mwn == 4'b0000);
    ld_op = mr && !st_op;
    size = 4;
    sgn = 0;
    if (st_op) size = (st == 3'd1) ? 1 : (st == 3'd2) ? 2 : 4;
    else if (ld_op) begin
      case (ld)
        3'd1: begin size = 1; sgn = 1; end
        3'd2: begin size = 2; sgn = 1; end
        3'd3: size = 2;
        3'd4: size = 1;
        default: size = 4;
      endcase
    end
    lsb = int'(a[1:0]);
    mis = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (st_op || ld_op) mis = (lsb % size) != 0;
`endif
    acc = (st_op || ld_op) && !mis;
    start = (lsb / size) * size;
    web = 4'hF;
    di = 32'h0;
    rd = 32'h0;
    if (acc && st_op) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= start && i < start + size) web[i] = 1'b0;
        di[8*i +: 8] = wd[8*(i % size) +: 8];
      end
    end
    if (acc && ld_op) begin
      m = (64'd1 << (8 * size)) - 1;
      v = (longint'(mdo) >> (8 * start)) & m;
      if (sgn && v[8*size-1]) v = v | ~m;
      rd = v[31:0];
    end
  endtask

  // Issue one request and act as the memory, acking after dly cs cycles.
  task automatic run_op(
    input logic mr, input logic [3:0] mwn,
    input logic [2:0] ld, input logic [2:0] st,
    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mdo,
    input int dly,
    output int lat, output int cs_n,
    output logic [3:0] web, output logic [31:0] da,
    output logic [31:0] di, output logic [31:0] rd,
    output logic mis, output bit stable, output bit pulse1);
    bit done;
    @(negedge clk);
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    mem_read = mr;
    mem_write_n = mwn;
    load = ld;
    store = st;
    addr = a;
    wdata = wd;
    dm_do = mdo;
    @(negedge clk);
    req_valid = 1'b0;
    mem_read = 1'($urandom);
    mem_write_n = 4'($urandom);
    load = 3'($urandom);
    store = 3'($urandom);
    addr = $urandom;
    wdata = $urandom;
    lat = 1;
    cs_n = 0;
    stable = 1;
    web = 4'hF;
    da = 32'h0;
    di = 32'h0;
    rd = 32'h0;
    mis = 1'b0;
    done = 0;
    while (!done && lat < 64) begin
      if (dm_cs) begin
        if (cs_n == 0) begin
          web = dm_web;
          da = dm_addr;
          di = dm_di;
        end else if (dm_web !== web || dm_addr !== da || dm_di !== di) begin
          stable = 0;
        end
        cs_n++;
        dm_ack = (cs_n >= dly);
      end else begin
        dm_ack = 1'b0;
      end
      if (rsp_valid) begin
        rd = rdata;
        mis = misalign;
        done = 1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    dm_ack = 1'b0;
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    pulse1 = !rsp_valid && req_ready;
  endtask

  task automatic apply_and_check(
    input string tag, input logic mr, input logic [3:0] mwn,
    input logic [2:0] ld, input logic [2:0] st,
    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mdo,
    input int dly, input bit e_acc, input bit e_mis,
    input logic [3:0] e_web, input logic [31:0] e_di,
    input logic [31:0] e_rd);
    int lat;
    int cs_n;
    logic [3:0] web;
    logic [31:0] da;
    logic [31:0] di;
    logic [31:0] rd;
    logic mis;
    bit stable;
    bit pulse1;
    run_op(mr, mwn, ld, st, a, wd, mdo, dly,
           lat, cs_n, web, da, di, rd, mis, stable, pulse1);
    chk({tag, ".lat"}, lat, e_acc ? dly + 1 : 1);
    chk({tag, ".cs_cycles"}, cs_n, e_acc ? dly : 0);
    if (e_acc && cs_n > 0) begin
      chk({tag, ".dm_web"}, {28'b0, web}, {28'b0, e_web});
      chk({tag, ".dm_addr"}, da, a & 32'hFFFF_FFFC);
      chk({tag, ".dm_di"}, di, e_di);
      chk({tag, ".stable"}, {31'b0, stable}, 32'd1);
    end
    chk({tag, ".rdata"}, rd, e_rd);
    chk({tag, ".misalign"}, {31'b0, mis}, {31'b0, e_mis});
    chk({tag, ".pulse"}, {31'b0, pulse1}, 32'd1);
  endtask

  typedef struct {
    logic        mr;
    logic [3:0]  mwn;
    logic [2:0]  ld;
    logic [2:0]  st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mdo;
    int          dly;
    bit          e_acc;
    logic [3:0]  e_web;
    logic [31:0] e_di;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 3'd0, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0,
                 3, 1'b1, 4'b0000, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 3'd0, 3'd1, 32'h103, 32'h000000A5, 32'h0,
                 1, 1'b1, 4'b0111, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{1'b1, 4'hF, 3'd1, 3'd0, 32'h102, 32'h0, 32'h12F05678,
                 1, 1'b1, 4'b1111, 32'h0, 32'hFFFFFFF0};
    vecs[3]  = '{1'b1, 4'hF, 3'd4, 3'd0, 32'h102, 32'h0, 32'h12F05678,
                 1, 1'b1, 4'b1111, 32'h0, 32'h000000F0};
    vecs[4]  = '{1'b1, 4'hF, 3'd2, 3'd0, 32'h102, 32'h0, 32'h12F05678,
                 1, 1'b1, 4'b1111, 32'h0, 32'h000012F0};
    vecs[5]  = '{1'b0, 4'hF, 3'd0, 3'd0, 32'h100, 32'h12345678, 32'h55555555,
                 1, 1'b0, 4'b1111, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 3'd0, 3'd2, 32'h102, 32'h1234ABCD, 32'h0,
                 2, 1'b1, 4'b0011, 32'hABCDABCD, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, 3'd3, 3'd0, 32'h100, 32'h0, 32'h8001FFFE,
                 1, 1'b1, 4'b1111, 32'h0, 32'h0000FFFE};
    vecs[8]  = '{1'b1, 4'hF, 3'd2, 3'd0, 32'h100, 32'h0, 32'h8001FFFE,
                 1, 1'b1, 4'b1111, 32'h0, 32'hFFFFFFFE};
    vecs[9]  = '{1'b1, 4'h0, 3'd0, 3'd0, 32'h204, 32'h11223344, 32'h99999999,
                 1, 1'b1, 4'b0000, 32'h11223344, 32'h0};
    vecs[10] = '{1'b1, 4'hF, 3'd0, 3'd0, 32'h208, 32'h0, 32'hCAFEF00D,
                 2, 1'b1, 4'b1111, 32'h0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 4'hF, 3'd7, 3'd5, 32'h10C, 32'h0, 32'h89ABCDEF,
                 1, 1'b1, 4'b1111, 32'h0, 32'h89ABCDEF};
  end

  initial begin
    bit acc;
    bit mis;
    logic [3:0] web;
    logic [31:0] di;
    logic [31:0] rd;
    int lat;
    int cs_n;
    logic [31:0] da;
    logic mis_o;
    bit stable;
    bit pulse1;
    int sel;
    logic r_mr;
    logic [3:0] r_mwn;
    logic [2:0] r_ld;
    logic [2:0] r_st;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_mdo;
    int r_dly;
    int stray;

    rst = 1'b1;
    req_valid = 1'b0;
    mem_read = 1'b0;
    mem_write_n = 4'hF;
    load = 3'd0;
    store = 3'd0;
    addr = 32'h0;
    wdata = 32'h0;
    dm_do = 32'h0;
    dm_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.misalign", {31'b0, misalign}, 32'd0);
    chk("rst.dm_cs", {31'b0, dm_cs}, 32'd0);
    chk("rst.dm_web", {28'b0, dm_web}, 32'hF);
    chk("rst.dm_addr", dm_addr, 32'd0);
    chk("rst.dm_di", dm_di, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply_and_check($sformatf("vec%0d", i), vecs[i].mr, vecs[i].mwn,
                      vecs[i].ld, vecs[i].st, vecs[i].a, vecs[i].wd,
                      vecs[i].mdo, vecs[i].dly, vecs[i].e_acc, 1'b0,
                      vecs[i].e_web, vecs[i].e_di, vecs[i].e_rd);
    end

    run_op(1'b1, 4'hF, 3'd0, 3'd0, 32'h101, 32'h0, 32'hA1B2C3D4, 1,
           lat, cs_n, web, da, di, rd, mis_o, stable, pulse1);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_mis.cs_cycles", cs_n, 0);
    chk("lw_mis.lat", lat, 1);
    chk("lw_mis.misalign", {31'b0, mis_o}, 32'd1);
    chk("lw_mis.rdata", rd, 32'h0);
`else
    chk("lw_mis.cs_cycles", cs_n, 1);
    chk("lw_mis.dm_addr", da, 32'h100);
    chk("lw_mis.lat", lat, 2);
    chk("lw_mis.misalign", {31'b0, mis_o}, 32'd0);
    chk("lw_mis.rdata", rd, 32'hA1B2C3D4);
`endif

    dm_ack = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || dm_cs) stray++;
    end
    dm_ack = 1'b0;
    chk("idle_ack.stray", stray, 0);

    @(negedge clk);
    req_valid = 1'b1;
    mem_read = 1'b1;
    mem_write_n = 4'hF;
    load = 3'd0;
    addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.cs_first", {31'b0, dm_cs}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.dm_cs", {31'b0, dm_cs}, 32'd0);
    chk("abort.req_ready", {31'b0, req_ready}, 32'd1);
    stray = 0;
    repeat (3) begin
      if (rsp_valid) stray++;
      @(negedge clk);
    end
    chk("abort.no_rsp", stray, 0);
    apply_and_check("after_abort", 1'b0, 4'hF, 3'd0, 3'd0, 32'h0, 32'h0,
                    32'h0, 1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    apply_and_check("after_abort_lw", 1'b1, 4'hF, 3'd0, 3'd0, 32'h300, 32'h0,
                    32'h0BADF00D, 2, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0BADF00D);

    for (int k = 0; k < 200; k++) begin
      r_mr = 1'($urandom);
      sel = $urandom_range(0, 3);
      r_mwn = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
      r_ld = 3'($urandom);
      r_st = 3'($urandom);
      r_a = $urandom & 32'h0000FFFF;
      r_wd = $urandom;
      r_mdo = $urandom;
      r_dly = $urandom_range(1, 4);
      model(r_mr, r_mwn, r_ld, r_st, r_a, r_wd, r_mdo, acc, mis, web, di, rd);
      apply_and_check($sformatf("rnd%0d", k), r_mr, r_mwn, r_ld, r_st, r_a,
                      r_wd, r_mdo, r_dly, acc, mis, web, di, rd);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory byte-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block idle, request accepted when req_valid&&req_ready.
REQ-006 SHALL have port mem_read  input  1  load request (decoder MemRead).
REQ-007 SHALL have port mem_write_n  input  4  decoder MemWrite; 4'b0000 = store, 4'b1111 = no store.
REQ-008 SHALL have port load  input  3  0=LW, 1=LB, 2=LH, 3=LHU, 4=LBU.
REQ-009 SHALL have port store  input  3  0=SW, 1=SB, 2=SH.
REQ-010 SHALL have port addr  input  ADDR_W  byte address.
REQ-011 SHALL have port wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rdata  output  32  extended load result, valid with rsp_valid.
REQ-014 SHALL have port misalign  output  1  access fault flag, valid with rsp_valid.
REQ-015 SHALL have ports dm_cs (out 1), dm_web (out 4, active-low byte write enables), dm_addr (out ADDR_W, word aligned, low 2 bits 0), dm_di (out 32), dm_do (in 32), dm_ack (in 1, access complete).

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-017 SHALL latch all request fields on acceptance; inputs ignored outside IDLE.
REQ-018 SHALL classify request: store if mem_write_n==4'b0000 (store wins if mem_read also 1), load if mem_read=1, else no-op.
REQ-019 SHALL send no-op and misaligned requests IDLE -> RESP directly, dm_cs never asserted, rdata=0.
REQ-020 SHALL in ACCESS drive dm_cs=1, dm_addr={addr[ADDR_W-1:2],2'b00}, stay until dm_ack=1, then go to RESP.
REQ-021 SHALL for stores drive dm_web low on lanes: SW 4'b0000; SH lanes addr[1]*2+{0,1}; SB lane addr[1:0]; dm_di = wdata replicated (byte x4, half x2).
REQ-022 SHALL for loads drive dm_web=4'b1111, capture dm_do when dm_ack=1, select lane by addr[1:0], sign-extend LB/LH, zero-extend LBU/LHU, pass LW whole.
REQ-023 SHALL in RESP assert rsp_valid=1 for exactly one cycle, hold rdata/misalign that cycle, then return to IDLE.
REQ-024 SHALL drive dm_cs=0, dm_web=4'b1111 in IDLE and RESP.
REQ-025 SHALL give minimum latency 2 cycles accept-to-rsp_valid for memory accesses (dm_ack in first ACCESS cycle), 1 cycle for no-op/misaligned.
REQ-026 SHALL ignore dm_ack outside ACCESS; stores return rdata=0.
REQ-027 SHALL treat unlisted load/store codes as LW/SW.

Reset
REQ-028 SHALL on rst force IDLE, req_ready=1, rsp_valid=0, rdata=0, misalign=0, dm_cs=0, dm_web=4'b1111, dm_addr=0, dm_di=0.
REQ-029 SHALL on rst during ACCESS abort: dm_cs=0 next cycle, no rsp_valid for aborted request.

Configuration
REQ-030 SHALL with LSU_MISALIGN_CHECK_EN defined flag misalign=1 for LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]!=0, handled per REQ-019.
REQ-031 SHALL without LSU_MISALIGN_CHECK_EN tie misalign=0, ignore addr[0] for halfwords and addr[1:0] for words, always perform the access.

Verification
REQ-032 SHALL cover SW addr=0x100 wdata=0xDEADBEEF, dm_ack after 3 cycles -> dm_web=4'b0000, dm_addr=0x100, dm_di=0xDEADBEEF for 3 cycles, rsp_valid 1 cycle after ack.
REQ-033 SHALL cover SB addr=0x103 wdata=0x000000A5 -> dm_web=4'b0111, dm_di=0xA5A5A5A5.
REQ-034 SHALL cover LB addr=0x102 with dm_do=0x12F0_5678, immediate ack -> rdata=0xFFFFFFF0; LBU same -> 0x000000F0; LH addr=0x102 -> 0x000012F0.
REQ-035 SHALL cover LW addr=0x101 with LSU_MISALIGN_CHECK_EN -> dm_cs stays 0, rsp_valid next cycle, misalign=1, rdata=0; without macro -> access at 0x100, misalign=0.
REQ-036 SHALL cover rst asserted in 2nd ACCESS cycle of LW -> next cycle dm_cs=0, req_ready=1, no rsp_valid; new request accepted afterwards.
REQ-037 SHALL cover mem_read=0, mem_write_n=4'b1111 request -> no dm_cs, rsp_valid 1 cycle after accept, rdata=0.
